// File: rtl/seg7_scan.sv
// seg7_scan: four-digit multiplexed seven-segment scanner with a shadow
// register so a newly loaded value only appears at a frame boundary.
// Optional leading-zero blanking on digits 1..3: define SEG7_SCAN_LZB_EN.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   value, load   16-bit hex value (nibble k -> digit k), load strobe
//   pending       loaded value waiting for the next frame boundary
//   q             current digit index 0..3
//   frame         one-cycle pulse after each digit 3->0 wrap
//   an, seg       active-low digit enables and {g,f,e,d,c,b,a} segments
module seg7_scan #(
   parameter int DIV = 50000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] value,
   input  logic        load,
   output logic        pending,
   output logic [1:0]  q,
   output logic        frame,
   output logic [3:0]  an,
   output logic [6:0]  seg
);

   localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt;
   logic [15:0]   shadow;
   logic [15:0]   disp;
   logic          tick;
   logic          wrap;
   logic [3:0]    nib;
   logic [6:0]    seg_nx;

   function automatic logic [6:0] hex7(input logic [3:0] h);
      logic [6:0] s;
      case (h)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         default: s = 7'h0E;
      endcase
      return s;
   endfunction

   assign tick = (cnt == LAST);
   assign wrap = tick && (q == 2'd3);

   always_comb begin
      nib = disp[3:0];
      case (q)
         2'd1: nib = disp[7:4];
         2'd2: nib = disp[11:8];
         2'd3: nib = disp[15:12];
         default: nib = disp[3:0];
      endcase
   end

`ifdef SEG7_SCAN_LZB_EN
   logic blank;

   // A digit is blank when it and every digit to its left are zero.
   // Digit 0 is never blanked so a zero value still shows "0".
   always_comb begin
      blank = 1'b0;
      case (q)
         2'd1: blank = (disp[15:4] == 12'h000);
         2'd2: blank = (disp[15:8] == 8'h00);
         2'd3: blank = (disp[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end

   assign seg_nx = blank ? 7'h7F : hex7(nib);
`else
   assign seg_nx = hex7(nib);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         q       <= 2'd0;
         frame   <= 1'b0;
         pending <= 1'b0;
         shadow  <= 16'h0000;
         disp    <= 16'h0000;
         an      <= 4'b1111;
         seg     <= 7'h7F;
      end else begin
         cnt   <= tick ? '0 : cnt + 1'b1;
         q     <= tick ? q + 2'd1 : q;
         frame <= wrap;
         // A load landing on the boundary goes straight to the display.
         if (load && wrap) begin
            disp    <= value;
            shadow  <= value;
            pending <= 1'b0;
         end else if (load) begin
            shadow  <= value;
            pending <= 1'b1;
         end else if (wrap && pending) begin
            disp    <= shadow;
            pending <= 1'b0;
         end
         an  <= ~(4'b0001 << q);
         seg <= seg_nx;
      end
   end

endmodule

// File: doc/seg7_scan.md
SEG7_SCAN -- requirements
Module: seg7_scan

Interface
REQ-001 Parameter DIV, default 50000, prescaler period in clk cycles per digit (legal range 2..2^20).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 value  input  16  hex value to display; nibble k drives digit k (digit 0 rightmost).
REQ-005 load  input  1  single-cycle strobe; value is sampled when load=1.
REQ-006 pending  output  1  a loaded value is waiting for the next frame boundary.
REQ-007 q  output  2  current digit index, 0..3.
REQ-008 frame  output  1  one-cycle pulse at each digit 3->0 wrap.
REQ-009 an  output  4  digit enables, active-low, registered.
REQ-010 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.

Function
REQ-011 Prescaler counts 0..DIV-1 and wraps; tick=1 in the cycle where count==DIV-1.
REQ-012 On tick, q shall advance by 1, wrapping 3->0; otherwise q shall hold.
REQ-013 frame shall be registered, =1 exactly in the cycle after a tick with q==3 (q reads 0 that cycle).
REQ-014 load=1 shall capture value into shadow and set pending=1; a later load before transfer overwrites shadow (last wins).
REQ-015 On tick with q==3 and pending=1, disp<=shadow and pending<=0.
REQ-016 load coinciding with tick and q==3 shall bypass: disp<=value, pending<=0, shadow<=value.
REQ-017 disp shall change only at frame boundaries; value changes without load have no effect.
REQ-018 an shall be registered ~(4'b0001<<q), lagging q by one cycle; exactly one bit low after the first post-reset cycle.
REQ-019 seg shall be registered from disp nibble q, same cycle as an.
REQ-020 Hex decode 0..F (seg hex): 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
REQ-021 Digit 0 shall never be blanked.

Reset
REQ-022 rst=1 shall force: prescaler=0, q=0, frame=0, pending=0, shadow=0, disp=0, an=4'b1111, seg=7'h7F.
REQ-023 rst shall override load and tick in the same cycle; a pending value is discarded.
REQ-024 After rst deasserts, first tick occurs DIV cycles later; an/seg valid one cycle after deassertion (digit 0 showing "0").

Configuration
REQ-025 Macro SEG7_SCAN_LZB_EN enables leading-zero blanking.
REQ-026 Defined: digit k (k=1..3) shall drive seg=7'h7F when disp nibbles k..3 are all zero; an still scans normally.
REQ-027 Undefined: all four digits shall always show their hex decode; no blanking logic is present.

Verification (bench uses DIV=4)
REQ-028 rst 2 cycles, release -> an=1110, seg=40, q=0; q steps 0,1,2,3,0 every 4 cycles; frame one pulse per 16 cycles.
REQ-029 load value=16'h1A3F at q==1 -> pending=1 until next q 3->0 wrap, then pending=0; an 1110/1101/1011/0111 show seg 0E,30,08,79.
REQ-030 load 16'h1111 then 16'h2222 before wrap -> after wrap all digits seg=24; 1111 never displayed.
REQ-031 load 16'h5555 in the tick cycle with q==3 -> pending stays 0, digit 0 shows seg=12 in the frame starting that cycle.
REQ-032 load 16'h00A0, then rst mid-frame with pending=1 -> all outputs return to reset values, pending=0, display 0000.
REQ-033 SEG7_SCAN_LZB_EN defined, disp=16'h00A0 -> digits 3,2 seg=7F, digit 1 seg=08, digit 0 seg=40; undefined -> 40,40,08,40.
